mul_acc_stage: RTL and testbench
================================

MUL_ACC_STAGE -- requirements
Module: mul_acc_stage

Interface
REQ-001 SHALL have parameter BIT_DEPTH, default 32, operand width; power of two, >= 2.
REQ-002 SHALL have parameter ACC_GUARD, default 8, accumulator guard bits; ACC_W = 2*BIT_DEPTH + ACC_GUARD.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operand pair a/b/in_last valid.
REQ-006 SHALL have port in_ready  output  1  stage accepts operand pair.
REQ-007 SHALL have port a  input  BIT_DEPTH  unsigned multiplicand.
REQ-008 SHALL have port b  input  BIT_DEPTH  unsigned multiplier.
REQ-009 SHALL have port in_last  input  1  final beat of current packet.
REQ-010 SHALL have port out_valid  output  1  out_sum/out_count/out_ovf valid.
REQ-011 SHALL have port out_ready  input  1  downstream takes result.
REQ-012 SHALL have port out_sum  output  ACC_W  sum of a*b over packet, modulo 2^ACC_W.
REQ-013 SHALL have port out_count  output  16  beats in packet, saturating at 65535.
REQ-014 SHALL have port out_ovf  output  1  sticky: accumulator wrapped during packet.

Function
REQ-015 SHALL compute each product with the team's combinational n_bit_mul at BIT_DEPTH, fed from registered operands only.
REQ-016 SHALL accept a beat on the rising edge where in_valid & in_ready; a, b, in_last captured into stage-1 register, s1_valid set.
REQ-017 SHALL, on each edge with s1_valid, add zero-extended 2*BIT_DEPTH product into acc; first beat of packet loads acc = product (no stale add).
REQ-018 SHALL increment beat count per s1 beat; first beat loads 1; saturate at 65535, no wrap.
REQ-019 SHALL set overflow flag on carry out of bit ACC_W-1 of any add; cleared at packet start; acc wraps modulo 2^ACC_W.
REQ-020 SHALL use two states: ACC (accumulating) and HOLD (result presented).
REQ-021 SHALL, when s1 beat has last set, register out_sum = final acc, out_count, out_ovf, assert out_valid and enter HOLD on that edge.
REQ-022 SHALL have latency 2 edges: last beat accepted at edge t -> out_valid high after edge t+1.
REQ-023 SHALL drive in_ready = (state==ACC) & !(s1_valid & s1_last), from registers only; no combinational in->out path.
REQ-024 SHALL in HOLD keep out_valid high and out_sum/out_count/out_ovf stable until out_ready sampled high.
REQ-025 SHALL on out_valid & out_ready: clear out_valid, return to ACC, arm first-beat flag; in_ready high the following cycle.
REQ-026 SHALL ignore out_ready while out_valid low.
REQ-027 SHALL handle a single-beat packet (in_last on first beat): out_sum = a*b, out_count = 1.
REQ-028 SHALL allow back-to-back beats every cycle within a packet; in_valid gaps do not alter acc or count.
REQ-029 SHALL ignore a, b, in_last when in_valid low or in_ready low (no acceptance).

Reset
REQ-030 SHALL on rst_n low, immediately and asynchronously: state=ACC, s1_valid=0, acc=0, count=0, overflow=0, out_valid=0, out_sum=0, out_count=0, out_ovf=0, first-beat flag armed.
REQ-031 SHALL, after reset mid-packet or mid-HOLD, discard partial packet/held result; in_ready=1 on first cycle after rst_n high.
REQ-032 SHALL leave stage idle after reset release until first accepted beat.

Verification (BIT_DEPTH=4, ACC_GUARD=2, ACC_W=10)
REQ-033 SHALL test: beats (3,5),(2,7),(15,15,last), out_ready=1 -> out_sum=254, out_count=3, out_ovf=0, out_valid 2 edges after last accept.
REQ-034 SHALL test: five beats (15,15), last on 5th -> out_sum=101, out_count=5, out_ovf=1.
REQ-035 SHALL test: single beat (9,11,last), out_ready=0 for 4 cycles -> out_sum=99 stable, in_ready=0 throughout, then handshake -> in_ready=1 next cycle.
REQ-036 SHALL test: second packet (1,1,last) right after handshake -> out_sum=1, out_count=1 (no residue from first packet).
REQ-037 SHALL test: rst_n low after two beats of a packet -> all outputs 0 asynchronously; new packet (2,3,last) -> out_sum=6, out_count=1.
REQ-038 SHALL test: in_valid toggling 1/0 across 4-beat packet of (1,2) -> out_sum=8, out_count=4.

Source files
------------

// File: rtl/mul_acc_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mul_acc_stage (with n_bit_mul)                               |
// | Description : Pipelined unsigned multiply-accumulate over packets with a   |
// |               valid/ready input and a held, handshaked result.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

module n_bit_mul #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] p
);
    logic [2*WIDTH-1:0] w_pp [WIDTH];

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_pp
            assign w_pp[gi] = b[gi] ? ({{WIDTH{1'b0}}, a} << gi) : '0;
        end
    endgenerate

    always_comb begin
        p = '0;
        for (int i = 0; i < WIDTH; i++) begin
            p = p + w_pp[i];
        end
    end
endmodule

module mul_acc_stage #(
    parameter  int BIT_DEPTH = 32,
    parameter  int ACC_GUARD = 8,
    localparam int ACC_W     = 2*BIT_DEPTH + ACC_GUARD
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_DEPTH-1:0] a,
    input  logic [BIT_DEPTH-1:0] b,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_W-1:0]     out_sum,
    output logic [15:0]          out_count,
    output logic                 out_ovf
);
    localparam int PROD_W = 2*BIT_DEPTH;

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t                 r_state;
    logic                   r_s1_valid;
    logic [BIT_DEPTH-1:0]   r_s1_a;
    logic [BIT_DEPTH-1:0]   r_s1_b;
    logic                   r_s1_last;
    logic [ACC_W-1:0]       r_acc;
    logic [15:0]            r_count;
    logic                   r_ovf;
    logic                   r_first;

    logic [PROD_W-1:0]      w_prod;
    logic [ACC_W-1:0]       w_acc_base;
    logic [ACC_W:0]         w_sum;
    logic                   w_ovf_next;
    logic [15:0]            w_count_next;
    logic                   w_accept;

    n_bit_mul #(
        .WIDTH (BIT_DEPTH)
    ) u_mul (
        .a (r_s1_a),
        .b (r_s1_b),
        .p (w_prod)
    );

    // Ready depends on state only, so upstream never sees a combinational loop.
    assign in_ready = (r_state == ST_ACC) && !(r_s1_valid && r_s1_last);
    assign w_accept = in_valid && in_ready;

    // First beat of a packet starts from zero so nothing stale is added.
    assign w_acc_base   = r_first ? '0 : r_acc;
    assign w_sum        = {1'b0, w_acc_base} + {{(ACC_W+1-PROD_W){1'b0}}, w_prod};
    assign w_ovf_next   = (r_first ? 1'b0 : r_ovf) | w_sum[ACC_W];
    assign w_count_next = r_first ? 16'd1 :
                          ((r_count == 16'hFFFF) ? r_count : r_count + 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_ACC;
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_last  <= 1'b0;
            r_acc      <= '0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
            r_first    <= 1'b1;
            out_valid  <= 1'b0;
            out_sum    <= '0;
            out_count  <= '0;
            out_ovf    <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_a    <= a;
                r_s1_b    <= b;
                r_s1_last <= in_last;
            end

            if (r_s1_valid) begin
                r_acc   <= w_sum[ACC_W-1:0];
                r_count <= w_count_next;
                r_ovf   <= w_ovf_next;
                r_first <= r_s1_last;
            end

            case (r_state)
                ST_ACC: begin
                    if (r_s1_valid && r_s1_last) begin
                        out_sum   <= w_sum[ACC_W-1:0];
                        out_count <= w_count_next;
                        out_ovf   <= w_ovf_next;
                        out_valid <= 1'b1;
                        r_state   <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_first   <= 1'b1;
                        r_state   <= ST_ACC;
                    end
                end
                default: r_state <= ST_ACC;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mul_acc_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mul_acc_stage                                             |
// | Description : Directed, table-driven bench for mul_acc_stage (4-bit ops).  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mul_acc_stage;
    localparam int BD    = 4;
    localparam int GUARD = 2;
    localparam int AW    = 2*BD + GUARD;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [BD-1:0] a = '0;
    logic [BD-1:0] b = '0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [AW-1:0] out_sum;
    logic [15:0]   out_count;
    logic          out_ovf;

    int total = 0;
    int bad   = 0;

    mul_acc_stage #(.BIT_DEPTH(BD), .ACC_GUARD(GUARD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BD-1:0] va;
        logic [BD-1:0] vb;
        logic          vlast;
        logic [AW-1:0] esum;
        logic [15:0]   ecnt;
        logic          eovf;
    } vec_t;

    vec_t vec [13];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Called right after a falling edge; returns right after the falling edge
    // that follows the accepting rising edge, with in_valid dropped.
    task automatic send_beat(input logic [BD-1:0] ta, input logic [BD-1:0] tb, input logic tl);
        int n = 0;
        a = ta; b = tb; in_last = tl; in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic get_result(input string tag, input logic [AW-1:0] es,
                              input logic [15:0] ec, input logic eo);
        int n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, n, 1);
        chk({tag, "_sum"}, out_sum, es);
        chk({tag, "_count"}, out_count, ec);
        chk({tag, "_ovf"}, out_ovf, eo);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_valid_clr"}, out_valid, 0);
        chk({tag, "_ready_back"}, in_ready, 1);
    endtask

    initial begin
        vec[0]  = '{4'd3,  4'd5,  1'b0, 10'd0,   16'd0, 1'b0};
        vec[1]  = '{4'd2,  4'd7,  1'b0, 10'd0,   16'd0, 1'b0};
        vec[2]  = '{4'd15, 4'd15, 1'b1, 10'd254, 16'd3, 1'b0};
        vec[3]  = '{4'd0,  4'd13, 1'b1, 10'd0,   16'd1, 1'b0};
        vec[4]  = '{4'd15, 4'd15, 1'b1, 10'd225, 16'd1, 1'b0};
        vec[5]  = '{4'd15, 4'd15, 1'b0, 10'd0,   16'd0, 1'b0};
        vec[6]  = '{4'd15, 4'd15, 1'b0, 10'd0,   16'd0, 1'b0};
        vec[7]  = '{4'd15, 4'd15, 1'b0, 10'd0,   16'd0, 1'b0};
        vec[8]  = '{4'd15, 4'd15, 1'b0, 10'd0,   16'd0, 1'b0};
        vec[9]  = '{4'd12, 4'd11, 1'b1, 10'd8,   16'd5, 1'b1};
        vec[10] = '{4'd1,  4'd15, 1'b1, 10'd15,  16'd1, 1'b0};
        vec[11] = '{4'd10, 4'd5,  1'b0, 10'd0,   16'd0, 1'b0};
        vec[12] = '{4'd6,  4'd6,  1'b1, 10'd86,  16'd2, 1'b0};

        // reset state
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            send_beat(vec[i].va, vec[i].vb, vec[i].vlast);
            if (vec[i].vlast) get_result($sformatf("vec%0d", i), vec[i].esum, vec[i].ecnt, vec[i].eovf);
        end

        // five saturating products: 1125 wraps to 101 with overflow
        for (int i = 0; i < 5; i++) send_beat(4'd15, 4'd15, i == 4);
        get_result("wrap5", 10'd101, 16'd5, 1'b1);

        // held result with a blocked, competing input
        send_beat(4'd9, 4'd11, 1'b1);
        for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
        a = 4'd7; b = 4'd7; in_last = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_sum", out_sum, 99);
            chk("hold_count", out_count, 1);
            chk("hold_in_ready", in_ready, 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("hold_release_valid", out_valid, 0);
        chk("hold_release_ready", in_ready, 1);

        // fresh packet right after the handshake
        send_beat(4'd1, 4'd1, 1'b1);
        get_result("second", 10'd1, 16'd1, 1'b0);

        // asynchronous reset in the middle of a packet
        send_beat(4'd3, 4'd3, 1'b0);
        send_beat(4'd4, 4'd4, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_sum", out_sum, 0);
        chk("arst_out_count", out_count, 0);
        chk("arst_out_ovf", out_ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("arst_in_ready", in_ready, 1);
        @(negedge clk);
        send_beat(4'd2, 4'd3, 1'b1);
        get_result("post_rst", 10'd6, 16'd1, 1'b0);

        // idle cycles between beats leave the accumulation untouched
        for (int i = 0; i < 4; i++) begin
            send_beat(4'd1, 4'd2, i == 3);
            if (i != 3) begin
                a = 4'd15; b = 4'd15;
                @(negedge clk);
            end
        end
        get_result("gaps", 10'd8, 16'd4, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 want 1");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
